// File: rtl/eval_assert_pkg.sv
// ----------------------------------------------------------------------------
// eval_assert_pkg
//   Shared types for the eval_assert_monitor protocol checker: the 2-bit
//   violation code and a helper that sizes channel-index fields.
// ----------------------------------------------------------------------------
package eval_assert_pkg;

    localparam int CODE_W = 2;

    // Numeric order doubles as reporting priority: lower value wins when a
    // channel trips several checks in the same cycle.
    typedef enum logic [CODE_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_UNSTABLE = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eval_assert_chan.sv
// ----------------------------------------------------------------------------
// eval_assert_chan
//   Checker for one valid/ready channel. Classifies the current cycle as
//   MISMATCH, UNSTABLE, TIMEOUT or clean, using one cycle of stall history and
//   a saturating stall-episode counter.
// Ports
//   clock_i    rising-edge clock
//   reset_i    synchronous active-high reset
//   chk_en_i   0 = no violations, history and stall counter cleared
//   valid_i    channel valid
//   ready_i    channel ready
//   data_i     payload
//   expect_i   expected payload on handshake
//   viol_o     this cycle violates (combinational, registered by the top)
//   code_o     highest-priority violation code this cycle
// ----------------------------------------------------------------------------
module eval_assert_chan
    import eval_assert_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             chk_en_i,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] expect_i,
    output logic             viol_o,
    output err_code_e        code_o
);

    localparam int                 SC_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0]    SC_LAST = SC_W'(TIMEOUT - 1);
    localparam logic [SC_W-1:0]    SC_TRIP = SC_W'(TIMEOUT);

    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic             prev_stall_q, prev_stall_d;
    logic [WIDTH-1:0] prev_data_q, prev_data_d;

    logic stall;
    logic mismatch;
    logic unstable;
    logic timeout;

    assign stall    = valid_i & ~ready_i;
    assign mismatch = chk_en_i & valid_i & ready_i & (data_i != expect_i);
    // A stalled beat must be re-presented unchanged: dropping valid or
    // changing data right after a stall both count.
    assign unstable = chk_en_i & prev_stall_q & (~valid_i | (data_i != prev_data_q));
    // stall_cnt_q counts earlier stall cycles of this episode, so LAST marks
    // the TIMEOUT-th one. Once the counter parks at TRIP it cannot refire.
    assign timeout  = chk_en_i & stall & (stall_cnt_q == SC_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        stall_cnt_d  = '0;
        prev_stall_d = chk_en_i & stall;
        prev_data_d  = data_i;
        viol_o       = mismatch | unstable | timeout;
        code_o       = ERR_NONE;

        if (chk_en_i && stall) begin
            stall_cnt_d = (stall_cnt_q == SC_TRIP) ? stall_cnt_q : stall_cnt_q + SC_W'(1);
        end

        if (mismatch)      code_o = ERR_MISMATCH;
        else if (unstable) code_o = ERR_UNSTABLE;
        else if (timeout)  code_o = ERR_TIMEOUT;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other; blocking here would create ordering races.
    // The payload history is reset too even though it is only read behind
    // prev_stall_q, which keeps X out of the comparator after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q  <= '0;
            prev_stall_q <= 1'b0;
            prev_data_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            prev_stall_q <= prev_stall_d;
            prev_data_q  <= prev_data_d;
        end
    end

endmodule

// File: rtl/eval_assert_monitor.sv
// ----------------------------------------------------------------------------
// eval_assert_monitor
//   Multi-channel runtime protocol checker. One eval_assert_chan per channel;
//   this level registers the per-cycle violation flag, a sticky flag, the
//   first failing channel/code and a saturating violation count. In
//   simulation each violation is reported and can stop the run.
// Ports
//   clock_i           rising-edge clock
//   reset_i           synchronous active-high reset
//   chk_en_i          0 = checking bypassed, status outputs hold
//   clr_i             clear sticky, first-failure capture and count
//   ch_valid_i        per-channel valid
//   ch_ready_i        per-channel ready
//   ch_data_i         payloads, channel i at [i*WIDTH +: WIDTH]
//   ch_expect_i       expected payloads, same packing
//   err_any_o         a violation occurred on the previous cycle
//   err_sticky_o      any violation since reset/clr
//   err_first_ch_o    channel of the first recorded violation
//   err_first_code_o  code of the first recorded violation
//   err_count_o       saturating count of channel-violations
// ----------------------------------------------------------------------------
module eval_assert_monitor
    import eval_assert_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  WIDTH    = 32,
    parameter int  TIMEOUT  = 64,
    parameter int  CNT_W    = 16,
    parameter bit  FATAL_EN = 1'b1,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      chk_en_i,
    input  logic                      clr_i,
    input  logic [CHANNELS-1:0]       ch_valid_i,
    input  logic [CHANNELS-1:0]       ch_ready_i,
    input  logic [CHANNELS*WIDTH-1:0] ch_data_i,
    input  logic [CHANNELS*WIDTH-1:0] ch_expect_i,
    output logic                      err_any_o,
    output logic                      err_sticky_o,
    output logic [CH_W-1:0]           err_first_ch_o,
    output err_code_e                 err_first_code_o,
    output logic [CNT_W-1:0]          err_count_o
);

    localparam int               PC_W    = $clog2(CHANNELS + 1);
    localparam int               SUM_W   = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CHANNELS-1:0] viol;
    err_code_e           codes [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        eval_assert_chan #(
            .WIDTH   (WIDTH),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clock_i  (clock_i),
            .reset_i  (reset_i),
            .chk_en_i (chk_en_i),
            .valid_i  (ch_valid_i[g]),
            .ready_i  (ch_ready_i[g]),
            .data_i   (ch_data_i[g*WIDTH +: WIDTH]),
            .expect_i (ch_expect_i[g*WIDTH +: WIDTH]),
            .viol_o   (viol[g]),
            .code_o   (codes[g])
        );
    end

    logic             any_q, any_d;
    logic             sticky_q, sticky_d;
    logic [CH_W-1:0]  first_ch_q, first_ch_d;
    err_code_e        first_code_q, first_code_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PC_W-1:0]  popcnt;
    logic [CH_W-1:0]  low_ch;
    err_code_e        low_code;
    logic             base_sticky;
    logic [CNT_W-1:0] base_count;
    logic [SUM_W-1:0] sum;

    always_comb begin
        popcnt   = '0;
        low_ch   = '0;
        low_code = ERR_NONE;
        // Walk downwards so the lowest violating index is the last one written.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            popcnt = popcnt + PC_W'(viol[i]);
            if (viol[i]) begin
                low_ch   = CH_W'(i);
                low_code = codes[i];
            end
        end

        // clr acts first; the same cycle's violations then land on the
        // cleared state.
        base_sticky  = clr_i ? 1'b0 : sticky_q;
        base_count   = clr_i ? '0   : count_q;
        first_ch_d   = clr_i ? '0   : first_ch_q;
        first_code_d = clr_i ? ERR_NONE : first_code_q;

        any_d    = |viol;
        sticky_d = base_sticky | (|viol);
        if ((|viol) && !base_sticky) begin
            first_ch_d   = low_ch;
            first_code_d = low_code;
        end

        sum     = SUM_W'(base_count) + SUM_W'(popcnt);
        count_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            any_q        <= 1'b0;
            sticky_q     <= 1'b0;
            first_ch_q   <= '0;
            first_code_q <= ERR_NONE;
            count_q      <= '0;
        end else begin
            any_q        <= any_d;
            sticky_q     <= sticky_d;
            first_ch_q   <= first_ch_d;
            first_code_q <= first_code_d;
            count_q      <= count_d;
        end
    end

    assign err_any_o        = any_q;
    assign err_sticky_o     = sticky_q;
    assign err_first_ch_o   = first_ch_q;
    assign err_first_code_o = first_code_q;
    assign err_count_o      = count_q;

`ifndef SYNTHESIS
    function automatic string code_name(input err_code_e c);
        case (c)
            ERR_MISMATCH: return "payload mismatch";
            ERR_UNSTABLE: return "unstable while stalled";
            ERR_TIMEOUT:  return "stall timeout";
            default:      return "none";
        endcase
    endfunction

    always @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (viol[i]) begin
                    $display("eval_assert_monitor %m: channel %0d code %0d (%s) at %0t",
                             i, codes[i], code_name(codes[i]), $time);
                    if (FATAL_EN) begin
                        $fatal(1, "eval_assert_monitor %m: channel %0d code %0d", i, codes[i]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_eval_assert_monitor.sv
module tb_eval_assert_monitor;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 32;
    localparam int TIMEOUT  = 64;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      chk_en;
    logic                      clr;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       ready;
    logic [CHANNELS*WIDTH-1:0] data;
    logic [CHANNELS*WIDTH-1:0] expt;

    logic        any_o,    sat_any_o;
    logic        sticky_o, sat_sticky_o;
    logic [1:0]  ch_o,     sat_ch_o;
    logic [1:0]  code_o,   sat_code_o;
    logic [15:0] cnt_o;
    logic [1:0]  sat_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eval_assert_monitor #(
        .CHANNELS (CHANNELS), .WIDTH (WIDTH), .TIMEOUT (TIMEOUT),
        .CNT_W (16), .FATAL_EN (1'b0)
    ) dut (
        .clock_i (clk), .reset_i (reset), .chk_en_i (chk_en), .clr_i (clr),
        .ch_valid_i (valid), .ch_ready_i (ready), .ch_data_i (data), .ch_expect_i (expt),
        .err_any_o (any_o), .err_sticky_o (sticky_o), .err_first_ch_o (ch_o),
        .err_first_code_o (code_o), .err_count_o (cnt_o)
    );

    // Same stimulus, 2-bit counter: exercises saturation.
    eval_assert_monitor #(
        .CHANNELS (CHANNELS), .WIDTH (WIDTH), .TIMEOUT (TIMEOUT),
        .CNT_W (2), .FATAL_EN (1'b0)
    ) dut_sat (
        .clock_i (clk), .reset_i (reset), .chk_en_i (chk_en), .clr_i (clr),
        .ch_valid_i (valid), .ch_ready_i (ready), .ch_data_i (data), .ch_expect_i (expt),
        .err_any_o (sat_any_o), .err_sticky_o (sat_sticky_o), .err_first_ch_o (sat_ch_o),
        .err_first_code_o (sat_code_o), .err_count_o (sat_cnt_o)
    );

    typedef struct {
        logic        chk_en;
        logic        clr;
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic [127:0] data;
        logic [127:0] expt;
        logic        e_any;
        logic        e_sticky;
        logic [1:0]  e_ch;
        logic [1:0]  e_code;
        logic [15:0] e_cnt;
        logic [1:0]  e_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] pk(input logic [31:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t row(input logic en, cl, input logic [3:0] v, r,
                                 input logic [127:0] d, e,
                                 input logic a, s, input logic [1:0] c, k,
                                 input logic [15:0] n, input logic [1:0] sn);
        vec_t x;
        x.chk_en = en; x.clr = cl; x.valid = v; x.ready = r; x.data = d; x.expt = e;
        x.e_any = a; x.e_sticky = s; x.e_ch = c; x.e_code = k; x.e_cnt = n; x.e_sat = sn;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag, input logic a, s, input logic [1:0] c, k,
                             input logic [15:0] n, input logic [1:0] sn);
        check({tag, " err_any"},    32'(any_o),    32'(a));
        check({tag, " err_sticky"}, 32'(sticky_o), 32'(s));
        check({tag, " first_ch"},   32'(ch_o),     32'(c));
        check({tag, " first_code"}, 32'(code_o),   32'(k));
        check({tag, " count"},      32'(cnt_o),    32'(n));
        check({tag, " sat_count"},  32'(sat_cnt_o), 32'(sn));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, cl, input logic [3:0] v, r, input logic [127:0] d, e);
        chk_en = en; clr = cl; valid = v; ready = r; data = d; expt = e;
    endtask

    initial begin
        // Rows: inputs for one cycle, then outputs expected after that edge.
        //                   en cl valid    ready    data                         expect                      any st ch cd cnt sat
        vecs.push_back(row(1, 0, 4'b0000, 4'b0000, '0,                          '0,                          0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 0, 4'b0100, 4'b0100, pk(0, 32'h1234, 0, 0),       pk(0, 32'h1235, 0, 0),       1, 1, 2, 1, 1, 1));
        vecs.push_back(row(1, 0, 4'b0000, 4'b0000, '0,                          '0,                          0, 1, 2, 1, 1, 1));
        vecs.push_back(row(1, 0, 4'b0100, 4'b0100, pk(0, 32'h55, 0, 0),         pk(0, 32'h55, 0, 0),         0, 1, 2, 1, 1, 1));
        vecs.push_back(row(1, 1, 4'b0000, 4'b0000, '0,                          '0,                          0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 0, 4'b0001, 4'b0000, pk(0, 0, 0, 32'hA),          '0,                          0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 0, 4'b0001, 4'b0000, pk(0, 0, 0, 32'hB),          '0,                          1, 1, 0, 2, 1, 1));
        vecs.push_back(row(1, 0, 4'b0000, 4'b0000, '0,                          '0,                          1, 1, 0, 2, 2, 2));
        vecs.push_back(row(1, 0, 4'b0000, 4'b0000, '0,                          '0,                          0, 1, 0, 2, 2, 2));
        vecs.push_back(row(0, 0, 4'b0001, 4'b0000, pk(0, 0, 0, 32'hA),          '0,                          0, 1, 0, 2, 2, 2));
        vecs.push_back(row(0, 0, 4'b0001, 4'b0000, pk(0, 0, 0, 32'hB),          '0,                          0, 1, 0, 2, 2, 2));
        vecs.push_back(row(1, 0, 4'b0001, 4'b0000, pk(0, 0, 0, 32'hC),          '0,                          0, 1, 0, 2, 2, 2));
        vecs.push_back(row(1, 0, 4'b0001, 4'b0001, pk(0, 0, 0, 32'hC),          pk(0, 0, 0, 32'hC),          0, 1, 0, 2, 2, 2));
        vecs.push_back(row(1, 1, 4'b0000, 4'b0000, '0,                          '0,                          0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 0, 4'b1010, 4'b1010, pk(3, 0, 1, 0),              pk(4, 0, 2, 0),              1, 1, 1, 1, 2, 2));
        vecs.push_back(row(1, 0, 4'b1101, 4'b1101, pk(5, 6, 0, 7),              '0,                          1, 1, 1, 1, 5, 3));
        vecs.push_back(row(1, 0, 4'b0001, 4'b0001, pk(0, 0, 0, 1),              '0,                          1, 1, 1, 1, 6, 3));
        vecs.push_back(row(1, 1, 4'b0001, 4'b0001, pk(0, 0, 0, 1),              '0,                          1, 1, 0, 1, 1, 1));
        vecs.push_back(row(1, 0, 4'b0010, 4'b0000, pk(0, 0, 7, 0),              '0,                          0, 1, 0, 1, 1, 1));
        vecs.push_back(row(1, 1, 4'b0010, 4'b0010, pk(0, 0, 8, 0),              pk(0, 0, 9, 0),              1, 1, 1, 1, 1, 1));
        vecs.push_back(row(1, 0, 4'b0010, 4'b0000, pk(0, 0, 5, 0),              '0,                          0, 1, 1, 1, 1, 1));
        vecs.push_back(row(1, 1, 4'b0010, 4'b0010, pk(0, 0, 6, 0),              pk(0, 0, 6, 0),              1, 1, 1, 2, 1, 1));
        vecs.push_back(row(1, 0, 4'b0000, 4'b0000, '0,                          '0,                          0, 1, 1, 2, 1, 1));

        // Reset state, then 100 idle cycles with nothing flagged.
        reset = 1'b1;
        drive(1, 0, '0, '0, '0, '0);
        step();
        step();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].chk_en, vecs[i].clr, vecs[i].valid, vecs[i].ready, vecs[i].data, vecs[i].expt);
            step();
            check_out($sformatf("row%0d", i), vecs[i].e_any, vecs[i].e_sticky, vecs[i].e_ch,
                      vecs[i].e_code, vecs[i].e_cnt, vecs[i].e_sat);
        end

        // Watchdog: one report on the 64th stall cycle, none afterwards.
        drive(1, 1, '0, '0, '0, '0);
        step();
        check_out("wd_clr", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 4'b0010, 4'b0000, pk(0, 0, 32'h77, 0), pk(0, 0, 32'h77, 0));
        for (int k = 1; k <= 200; k++) begin
            step();
            check($sformatf("wd_stall%0d err_any", k), 32'(any_o), 32'(k == TIMEOUT));
            if (k == TIMEOUT) check_out("wd_trip", 1, 1, 1, 3, 1, 1);
        end
        check_out("wd_200", 0, 1, 1, 3, 1, 1);
        ready = 4'b0010;
        step();
        check_out("wd_release", 0, 1, 1, 3, 1, 1);

        // 63 stall cycles end before the limit.
        drive(1, 0, 4'b0010, 4'b0000, pk(0, 0, 32'h77, 0), pk(0, 0, 32'h77, 0));
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            step();
            check($sformatf("wd63_%0d err_any", k), 32'(any_o), 32'd0);
        end
        ready = 4'b0010;
        step();
        check_out("wd63_release", 0, 1, 1, 3, 1, 1);

        // Reset mid-episode: 40 + 30 stall cycles never reach the limit.
        ready = 4'b0000;
        for (int k = 0; k < 40; k++) step();
        check_out("rst_pre", 0, 1, 1, 3, 1, 1);
        reset = 1'b1;
        step();
        check_out("rst_mid", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("rst_stall%0d err_any", k), 32'(any_o), 32'd0);
        end
        ready = 4'b0010;
        step();
        check_out("rst_end", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
